// File: rtl/panel_pixel_fetch_pkg.sv
// Shared panel definitions used by the pixel fetcher and the scan driver.
// Holds the geometry defaults, the fetch FSM encoding, the framebuffer
// address layout {half, row[3:0], col[4:0]} and the FIFO entry format.
package panel_pixel_fetch_pkg;

  localparam int COLS_DEF = 32;
  localparam int ROWS_DEF = 16;
  localparam int BPC_DEF  = 8;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RD_TOP = 2'd1;
  localparam logic [1:0] ST_RD_BOT = 2'd2;

  localparam int ADDR_W   = 10;
  localparam int HALF_BIT = 9;
  localparam int ROW_W    = 4;
  localparam int ROW_LSB  = 5;
  localparam int COL_W    = 5;
  localparam int PIX_W    = 6;

  // data = {R0, G0, B0, R1, G1, B1}
  typedef struct packed {
    logic             last;
    logic [PIX_W-1:0] data;
  } pix_entry_t;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic half,
                                                input logic [ROW_W-1:0] row,
                                                input logic [COL_W-1:0] col);
    return {half, row, col};
  endfunction

  // Pick one bit-plane out of a packed {R, G, B} framebuffer word.
  function automatic logic [2:0] plane_bits(input logic [23:0] rgb,
                                            input logic [2:0]  plane);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = rgb[23:16];
    g = rgb[15:8];
    b = rgb[7:0];
    return {r[plane], g[plane], b[plane]};
  endfunction

endpackage

// File: rtl/panel_pixel_fetch_fifo2.sv
// pixel_fifo2: two-entry FIFO for fetched pixels.
// Ports: clk, resetn (async active-low), push_i/push_data_i, pop_i,
//        full_o, empty_o, head_o (head entry, zero when empty).
// Push while full is only honoured when a pop happens in the same cycle.
module pixel_fifo2
  import panel_pixel_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       push_i,
  input  pix_entry_t push_data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output pix_entry_t head_o
);

  pix_entry_t mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Head is forced to zero when empty so the pixel outputs read 0 at idle.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/panel_pixel_fetch.sv
// panel_pixel_fetch: fetches one row/bit-plane line of a two-half LED panel.
// Each column needs a top-half read then a bottom-half read; the selected
// plane bit of each colour is packed into a 6-bit pixel and queued.
// Ports: clk, resetn (async active-low); req_valid/req_ready/req_row/
//        req_plane (line request); mem_rd/mem_addr/mem_rdata (framebuffer,
//        1-cycle read latency); pix_valid/pix_ready/pix_data/pix_last
//        (pixel stream); busy (line activity).
//
// state     | meaning
// ----------+------------------------------------------------------
// ST_IDLE   | waiting for a request (req_ready high)
// ST_RD_TOP | issue top-half read of column x once credit allows
// ST_RD_BOT | issue bottom-half read of column x, then advance x
module panel_pixel_fetch
  import panel_pixel_fetch_pkg::*;
#(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF,
  parameter int BPC  = BPC_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ROW_W-1:0]   req_row,
  input  logic [2:0]         req_plane,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [23:0]        mem_rdata,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_last,
  output logic               busy
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
  // Panels have a power-of-two scan count, so the mask is the row modulus.
  localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'(ROWS - 1);

  logic [1:0]       state_q, state_d;
  logic [COL_W-1:0] x_q, x_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [2:0]       plane_q, plane_d;
  logic [1:0]       inflight_q, inflight_d;
  logic             rd_top_q, rd_bot_q, bot_last_q;
  logic [2:0]       top_rgb_q;

  logic       half;
  logic       top_issue;
  logic       credit;
  logic [1:0] occ;
  logic       push;
  logic       pop;
  logic       fifo_full;
  logic       fifo_empty;
  pix_entry_t push_entry;
  pix_entry_t head;

  assign req_ready = resetn && (state_q == ST_IDLE);
  assign occ       = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
  // Only registered counts are used, which still covers one pixel per 2 cycles.
  assign credit    = ({1'b0, occ} + {1'b0, inflight_q}) < 3'd2;

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    row_d     = row_q;
    plane_d   = plane_q;
    mem_rd    = 1'b0;
    half      = 1'b0;
    top_issue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          row_d   = req_row & ROW_MASK;
          plane_d = (int'(req_plane) >= BPC) ? 3'(BPC - 1) : req_plane;
          x_d     = '0;
          state_d = ST_RD_TOP;
        end
      end
      ST_RD_TOP: begin
        if (credit) begin
          mem_rd    = 1'b1;
          top_issue = 1'b1;
          state_d   = ST_RD_BOT;
        end
      end
      ST_RD_BOT: begin
        mem_rd = 1'b1;
        half   = 1'b1;
        if (x_q == LAST_COL) begin
          x_d     = '0;
          state_d = ST_IDLE;
        end else begin
          x_d     = x_q + COL_W'(1);
          state_d = ST_RD_TOP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_addr = mem_rd ? fb_addr(half, row_q, x_q) : '0;

  assign push            = rd_bot_q;
  assign push_entry.last = bot_last_q;
  assign push_entry.data = {top_rgb_q, plane_bits(mem_rdata, plane_q)};

  always_comb begin
    inflight_d = inflight_q;
    if (top_issue && !push)      inflight_d = inflight_q + 2'd1;
    else if (!top_issue && push) inflight_d = inflight_q - 2'd1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      row_q      <= '0;
      plane_q    <= '0;
      inflight_q <= 2'd0;
      rd_top_q   <= 1'b0;
      rd_bot_q   <= 1'b0;
      bot_last_q <= 1'b0;
      top_rgb_q  <= 3'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      row_q      <= row_d;
      plane_q    <= plane_d;
      inflight_q <= inflight_d;
      rd_top_q   <= top_issue;
      rd_bot_q   <= mem_rd && half;
      bot_last_q <= mem_rd && half && (x_q == LAST_COL);
      if (rd_top_q) top_rgb_q <= plane_bits(mem_rdata, plane_q);
    end
  end

  assign pop = pix_valid && pix_ready;

  pixel_fifo2 u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  assign pix_valid = !fifo_empty;
  assign pix_data  = head.data;
  assign pix_last  = head.last;
  assign busy      = (state_q != ST_IDLE) || (inflight_q != 2'd0) || !fifo_empty;

endmodule

// File: tb/tb_panel_pixel_fetch.sv
module tb_panel_pixel_fetch;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_row;
  logic [2:0]  req_plane;
  logic        mem_rd;
  logic [9:0]  mem_addr;
  logic [23:0] mem_rdata = 24'h0;
  logic        pix_valid;
  logic        pix_ready;
  logic [5:0]  pix_data;
  logic        pix_last;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  int fb_mode = 0;
  int ready_mode = 0;
  int rd_count = 0;
  int npl = 0;
  int busy_drop = 0;
  bit busy_watch = 0;
  bit stall_prev = 0;
  logic [6:0] held = '0;
  int cyc = 0;

  logic [6:0] exp_pix [$];
  logic [9:0] exp_addr [$];

  panel_pixel_fetch dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_row   (req_row),
    .req_plane (req_plane),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_last  (pix_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [23:0] fb_word(input logic [9:0] a);
    logic [31:0] h;
    case (fb_mode)
      0: return a[9] ? 24'h000001 : 24'h010000;
      1: return a[9] ? 24'h00FF00 : 24'h80FF7F;
      default: begin
        h = {22'b0, a} * 32'h9E3779B1;
        return h[31:8];
      end
    endcase
  endfunction

  function automatic logic [6:0] model_pix(input int row, input int p, input int col);
    logic [23:0] t;
    logic [23:0] b;
    t = fb_word({1'b0, 4'(row), 5'(col)});
    b = fb_word({1'b1, 4'(row), 5'(col)});
    return {(col == 31), t[16+p], t[8+p], t[p], b[16+p], b[8+p], b[p]};
  endfunction

  // Framebuffer: one-cycle read latency, garbage when not read.
  always @(posedge clk) begin
    cyc++;
    if (mem_rd === 1'b1) mem_rdata <= fb_word(mem_addr);
    else                 mem_rdata <= 24'hA5A5A5 ^ 24'(cyc);
  end

  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       pix_ready = 1'b0;
        1:       pix_ready = 1'b1;
        default: pix_ready = ($urandom_range(0, 99) < 30);
      endcase
    end
  end

  always @(negedge clk) begin
    if (resetn === 1'b1 && mem_rd === 1'b1) begin
      rd_count++;
      if (exp_addr.size() == 0) check("addr_unexpected", 32'(mem_addr), 32'h3FF);
      else check("mem_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (stall_prev && pix_valid === 1'b1) check("hold_data", 32'({pix_last, pix_data}), 32'(held));
      if (pix_valid === 1'b1 && pix_ready === 1'b1) begin
        if (pix_last === 1'b1) npl++;
        if (exp_pix.size() == 0) check("pix_unexpected", 32'({pix_last, pix_data}), 32'hFF);
        else check("pix", 32'({pix_last, pix_data}), 32'(exp_pix.pop_front()));
      end
      stall_prev = (pix_valid === 1'b1) && (pix_ready !== 1'b1);
      held = {pix_last, pix_data};
    end else begin
      stall_prev = 1'b0;
    end
    if (busy_watch && busy !== 1'b1) busy_drop++;
  end

  task automatic do_req(input int row, input int plane);
    int p;
    bit ok;
    ok = 1'b0;
    p = (plane >= 8) ? 7 : plane;
    req_row = 4'(row);
    req_plane = 3'(plane);
    req_valid = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1'b1;
        for (int c = 0; c < 32; c++) begin
          exp_pix.push_back(model_pix(row, p, c));
          exp_addr.push_back({1'b0, 4'(row), 5'(c)});
          exp_addr.push_back({1'b1, 4'(row), 5'(c)});
        end
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    check("req_accept", 32'(ok), 32'd1);
  endtask

  task automatic wait_drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((exp_pix.size() != 0 || exp_addr.size() != 0) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, 32'(exp_pix.size() + exp_addr.size()), 32'd0);
  endtask

  initial begin
    int nz;
    resetn = 1'b0;
    req_valid = 1'b0;
    req_row = '0;
    req_plane = '0;

    // Reset values
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_pix_valid", 32'(pix_valid), 32'd0);
    check("rst_pix_data", 32'({pix_last, pix_data}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("rel_req_ready", 32'(req_ready), 32'd1);

    // Row 3 plane 0, constant pattern, latency and rate
    fb_mode = 0;
    ready_mode = 1;
    @(posedge clk); #1;
    do_req(3, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("first_valid_latency", 32'(pix_valid), (k == 3) ? 32'd1 : 32'd0);
    end
    wait_drain("line_row3_rate", 64);
    check("row3_data_sample", 32'(model_pix(3, 0, 5)), 32'h21);

    // Plane 7
    fb_mode = 1;
    do_req(2, 7);
    wait_drain("line_plane7", 80);
    check("plane7_top_bits", 32'(model_pix(2, 7, 0) >> 3), 32'b0110);

    // pix_ready held low for 20 cycles
    fb_mode = 2;
    ready_mode = 0;
    @(posedge clk); #1;
    do_req(7, 4);
    rd_count = 0;
    repeat (20) begin @(posedge clk); #1; end
    check("stall_rd_count", 32'(rd_count), 32'd4);
    check("stall_pix_valid", 32'(pix_valid), 32'd1);
    check("stall_pending", 32'(exp_pix.size()), 32'd32);
    ready_mode = 1;
    wait_drain("line_stall", 120);

    // Random pix_ready
    ready_mode = 2;
    npl = 0;
    do_req(9, 3);
    wait_drain("line_random", 2000);
    check("random_last_count", 32'(npl), 32'd1);

    // Back-to-back rows 0 and 1
    ready_mode = 1;
    repeat (2) begin @(posedge clk); #1; end
    npl = 0;
    busy_drop = 0;
    do_req(0, 5);
    busy_watch = 1'b1;
    do_req(1, 6);
    wait_drain("line_b2b", 200);
    busy_watch = 1'b0;
    check("b2b_busy_cont", 32'(busy_drop), 32'd0);
    check("b2b_last_count", 32'(npl), 32'd2);
    repeat (2) begin @(posedge clk); #1; end
    check("idle_busy", 32'(busy), 32'd0);

    // Reset at column 10
    do_req(5, 2);
    nz = 0;
    for (int i = 0; i < 200 && nz == 0; i++) begin
      @(negedge clk);
      if (mem_rd === 1'b1 && mem_addr[9] === 1'b0 && mem_addr[4:0] === 5'd10) nz = 1;
    end
    check("reach_col10", 32'(nz), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_pix.delete();
    exp_addr.delete();
    @(negedge clk);
    check("mid_rst_outputs", 32'({req_ready, mem_rd, mem_addr, pix_valid, pix_data, pix_last, busy}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("mid_rel_req_ready", 32'(req_ready), 32'd1);
    nz = 0;
    repeat (8) begin
      @(negedge clk);
      if (pix_valid !== 1'b0 || mem_rd !== 1'b0) nz++;
    end
    check("post_rst_quiet", 32'(nz), 32'd0);
    @(posedge clk); #1;
    do_req(6, 1);
    wait_drain("line_after_rst", 80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/panel_pixel_fetch.md
PANEL_PIXEL_FETCH -- requirements
Module: panel_pixel_fetch

Interface
REQ-001 SHALL have parameters: COLS, default 32, pixels per panel row; ROWS, default 16, scan rows per half; BPC, default 8, bits per colour channel.
REQ-002 SHALL have ports: clk  in  1  the single clock, all logic on its rising edge.
REQ-003 SHALL have ports: resetn  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: req_valid  in  1  scanner requests one row/plane line.
REQ-005 SHALL have ports: req_ready  out  1  block accepts a request.
REQ-006 SHALL have ports: req_row  in  4  scan row, 0..ROWS-1; req_plane  in  3  bit-plane, 0..BPC-1.
REQ-007 SHALL have ports: mem_rd  out  1  framebuffer read strobe; mem_addr  out  10  framebuffer address {half, row[3:0], col[4:0]}.
REQ-008 SHALL have ports: mem_rdata  in  24  {R[7:0], G[7:0], B[7:0]}, valid exactly 1 cycle after mem_rd.
REQ-009 SHALL have ports: pix_valid  out  1; pix_ready  in  1; pix_data  out  6  {R0,G0,B0,R1,G1,B1}; pix_last  out  1  marks column COLS-1.
REQ-010 SHALL have ports: busy  out  1  high from request acceptance until the last pixel of that line is popped.

Function
REQ-011 SHALL implement states IDLE, RD_TOP, RD_BOT; req_ready = 1 only in IDLE.
REQ-012 SHALL, on req_valid && req_ready, latch row and plane, clear column counter x to 0, enter RD_TOP.
REQ-013 SHALL in RD_TOP, when credit is available (REQ-017), assert mem_rd with addr {0,row,x} and enter RD_BOT; otherwise hold, mem_rd = 0.
REQ-014 SHALL in RD_BOT assert mem_rd with addr {1,row,x} unconditionally, then enter RD_TOP with x+1, or IDLE if x = COLS-1.
REQ-015 SHALL, the cycle after a top read, capture R0/G0/B0 = mem_rdata bits R[plane], G[plane], B[plane]; the cycle after a bottom read, push {R0,G0,B0,R1,G1,B1} with last = (x was COLS-1) into the output FIFO.
REQ-016 SHALL buffer output in a 2-entry FIFO; pix_valid = FIFO not empty; pop on pix_valid && pix_ready; pix_data/pix_last from the head entry.
REQ-017 SHALL grant credit when FIFO occupancy plus in-flight pixels (top issued, not yet pushed) is < 2; no push ever overflows the FIFO.
REQ-018 SHALL allow simultaneous push and pop in one cycle with occupancy unchanged.
REQ-019 SHALL accept a new request in IDLE while the FIFO still holds pixels from the previous line; ordering preserved.
REQ-020 SHALL, with pix_ready held high, sustain one pixel per 2 cycles; first pix_valid 3 cycles after request acceptance.
REQ-021 SHALL treat req_plane >= BPC as plane BPC-1; req_row is used modulo 16.
REQ-022 SHALL hold pix_data and pix_last stable while pix_valid && !pix_ready.

Reset
REQ-023 SHALL, while resetn is low, force state IDLE, x = 0, FIFO empty, in-flight count 0, mem_rd = 0, mem_addr = 0, pix_valid = 0, pix_data = 0, pix_last = 0, busy = 0, req_ready = 0.
REQ-024 SHALL, on reset assertion mid-line, discard all pending pixels and in-flight reads; no push from a pre-reset read occurs after release.
REQ-025 SHALL assert req_ready in the first cycle after resetn deasserts.

Structure
REQ-026 SHALL place COLS/ROWS/BPC defaults, the state encoding and the mem_addr field layout in the shared panel package used by the scan driver.
REQ-027 SHALL implement the 2-entry FIFO as one sub-module, pixel_fifo2, with push/pop/full/empty ports.

Verification
REQ-028 SHALL check: row 3, plane 0, framebuffer top = 0x010000 and bottom = 0x000001 at all columns, pix_ready = 1 -> 32 pixels each 6'b100001, pix_last only on the 32nd, addresses 0x060..0x07F and 0x260..0x27F interleaved.
REQ-029 SHALL check: plane 7 with top 0x80FF7F -> R0 = 1, G0 = 1, B0 = 0 on every pixel.
REQ-030 SHALL check: pix_ready held low 20 cycles after acceptance -> exactly 2 pixels buffered, mem_rd stalls after the 2nd pixel's bottom read, no data lost after release.
REQ-031 SHALL check: random pix_ready at 30 % -> 32 pixels in column order, data matching a reference model, one pix_last.
REQ-032 SHALL check: back-to-back requests row 0 then row 1 -> 64 pixels in order, two pix_last pulses, busy high continuously.
REQ-033 SHALL check: resetn pulsed low at column 10 -> all outputs at reset values next cycle, pix_valid stays 0 until a new request, the new line starts at column 0.
